alu_seq_core: RTL

Parametrised sequential ALU core, the next generation of the team's 8-bit combinational ALU. It adds the following on a start/done handshake:
- registered outputs,
- an internal accumulator,
- multi-cycle unsigned multiply and divide,
- shift ops and a signed-overflow flag.

It sits behind the TinyTapeout pin wrapper, which maps operands and opcode from `ui_in`/`uio_in` and drives results onto `uo_out`/`uio_out`.

---
 rtl/alu_seq_core.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_core
//  Purpose  : Sequential ALU core with start/done handshake, registered
//             outputs, internal accumulator, shifts, signed-overflow flag and
//             multi-cycle unsigned multiply (shift-add) / divide (restoring).
//  Ports    : clk, rst_n (async, active low), ena (clock enable),
//             start/op/a/b (request, captured when idle),
//             busy/done (status), result/result_hi (data),
//             zero/carry/overflow/err (flags)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             err
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;          // counter must be able to hold WIDTH
    localparam int M  = WIDTH - 1;       // sign bit index

    localparam logic [3:0] c_op_add    = 4'd0;
    localparam logic [3:0] c_op_sub    = 4'd1;
    localparam logic [3:0] c_op_and    = 4'd2;
    localparam logic [3:0] c_op_or     = 4'd3;
    localparam logic [3:0] c_op_xor    = 4'd4;
    localparam logic [3:0] c_op_not    = 4'd5;
    localparam logic [3:0] c_op_shl    = 4'd6;
    localparam logic [3:0] c_op_shr    = 4'd7;
    localparam logic [3:0] c_op_sar    = 4'd8;
    localparam logic [3:0] c_op_mul    = 4'd9;
    localparam logic [3:0] c_op_div    = 4'd10;
    localparam logic [3:0] c_op_acc    = 4'd11;
    localparam logic [3:0] c_op_clracc = 4'd12;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ITER = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_is_div;
    logic [WIDTH-1:0] r_hi, r_lo, r_b, r_acc;

    // ---------------- single-cycle datapath (operates on live inputs) -----
    logic [SW-1:0]      w_amt;
    logic [WIDTH:0]     w_add, w_sub, w_acc_sum, w_shl, w_shr;
    logic signed [WIDTH:0] w_sar;
    logic [WIDTH-1:0]   w_res, w_res_hi, w_acc_nxt;
    logic               w_zero, w_carry, w_ovf, w_err, w_acc_we, w_long;

    assign w_amt     = b[SW-1:0];
    assign w_add     = {1'b0, a} + {1'b0, b};
    assign w_sub     = {1'b0, a} - {1'b0, b};
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, a};
    // One guard bit on each shifter captures the last bit shifted out;
    // with a zero amount the guard bit stays 0.
    assign w_shl     = {1'b0, a} << w_amt;
    assign w_shr     = {a, 1'b0} >> w_amt;
    assign w_sar     = $signed({a, 1'b0}) >>> w_amt;
    assign w_long    = (op == c_op_mul) || ((op == c_op_div) && (b != '0));

    always_comb begin
        w_res     = '0;
        w_res_hi  = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_err     = 1'b0;
        w_acc_we  = 1'b0;
        w_acc_nxt = r_acc;
        case (op)
            c_op_add: begin
                w_res   = w_add[M:0];
                w_carry = w_add[WIDTH];
                w_ovf   = (a[M] == b[M]) && (w_add[M] != a[M]);
            end
            c_op_sub: begin
                w_res   = w_sub[M:0];
                w_carry = w_sub[WIDTH];
                w_ovf   = (a[M] != b[M]) && (w_sub[M] != a[M]);
            end
            c_op_and: w_res = a & b;
            c_op_or:  w_res = a | b;
            c_op_xor: w_res = a ^ b;
            c_op_not: w_res = ~a;
            c_op_shl: begin
                w_res   = w_shl[M:0];
                w_carry = w_shl[WIDTH];
            end
            c_op_shr: begin
                w_res   = w_shr[WIDTH:1];
                w_carry = w_shr[0];
            end
            c_op_sar: begin
                w_res   = w_sar[WIDTH:1];
                w_carry = w_sar[0];
            end
            c_op_mul: begin
                w_res = '0;              // always takes the iterative path
            end
            c_op_div: begin              // only reached here when b == 0
                w_res    = '1;
                w_res_hi = a;
                w_err    = 1'b1;
            end
            c_op_acc: begin
                w_res     = w_acc_sum[M:0];
                w_carry   = w_acc_sum[WIDTH];
                w_ovf     = (r_acc[M] == a[M]) && (w_acc_sum[M] != r_acc[M]);
                w_acc_we  = 1'b1;
                w_acc_nxt = w_acc_sum[M:0];
            end
            c_op_clracc: begin
                w_acc_we  = 1'b1;
                w_acc_nxt = '0;
            end
            default: w_err = 1'b1;       // reserved opcodes
        endcase
    end

    assign w_zero = (w_res == '0);

    // ---------------- iterative datapath --------------------------------
    // MUL: {r_hi,r_lo} starts as {0,a}; each step conditionally adds b to
    // the high half and shifts the pair right.
    // DIV: r_lo starts as the dividend and fills with quotient bits from
    // the right while r_hi holds the partial remainder.
    logic [WIDTH:0]   w_mul_sum, w_div_trial, w_div_diff;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo, w_div_hi, w_div_lo;
    logic [WIDTH-1:0] w_step_hi, w_step_lo;
    logic             w_div_ok, w_last;

    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_hi    = w_mul_sum[WIDTH:1];
    assign w_mul_lo    = {w_mul_sum[0], r_lo[M:1]};
    assign w_div_trial = {r_hi, r_lo[M]};
    assign w_div_diff  = w_div_trial - {1'b0, r_b};
    assign w_div_ok    = ~w_div_diff[WIDTH];   // no borrow: divisor fits
    assign w_div_hi    = w_div_ok ? w_div_diff[M:0] : w_div_trial[M:0];
    assign w_div_lo    = {r_lo[WIDTH-2:0], w_div_ok};
    assign w_step_hi   = r_is_div ? w_div_hi : w_mul_hi;
    assign w_step_lo   = r_is_div ? w_div_lo : w_mul_lo;
    assign w_last      = (r_cnt == CW'(1));

    // ---------------- FSM ------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start && w_long) w_state_nxt = S_ITER;
            S_ITER: if (w_last)          w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   r_state <= S_IDLE;
        else if (ena) r_state <= w_state_nxt;
    end

    assign busy = (r_state == S_ITER);

    // ---------------- registers -------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    if (w_long) begin
                        r_cnt    <= CW'(WIDTH);
                        r_is_div <= (op == c_op_div);
                        r_b      <= b;
                        r_hi     <= '0;
                        r_lo     <= a;
                    end else begin
                        done      <= 1'b1;
                        result    <= w_res;
                        result_hi <= w_res_hi;
                        zero      <= w_zero;
                        carry     <= w_carry;
                        overflow  <= w_ovf;
                        err       <= w_err;
                        if (w_acc_we) r_acc <= w_acc_nxt;
                    end
                end
            end else begin
                r_hi  <= w_step_hi;
                r_lo  <= w_step_lo;
                r_cnt <= r_cnt - CW'(1);
                if (w_last) begin
                    done      <= 1'b1;
                    result    <= w_step_lo;
                    result_hi <= w_step_hi;
                    overflow  <= 1'b0;
                    err       <= 1'b0;
                    if (r_is_div) begin
                        zero  <= (w_step_lo == '0);
                        carry <= 1'b0;
                    end else begin
                        zero  <= ({w_step_hi, w_step_lo} == '0);
                        carry <= (w_step_hi != '0);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
